multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high; forces the Fetch state.
REQ-005 op  input  7  instruction opcode, bits [6:0].
REQ-006 funct3  input  3  instruction bits [14:12].
REQ-007 funct7b5  input  1  instruction bit 30.
REQ-008 Zero  input  1  ALU zero flag for the current cycle.
REQ-009 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  output  1 each  datapath enables and selects.
REQ-010 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each  datapath mux selects.
REQ-011 ALUControl  output  3  ALU operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-012 state  output  4  current state encoding, for debug only.

Function
REQ-013 The state register SHALL use these encodings: Fetch=0, Decode=1, MemAdr=2, MemRead=3, MemWB=4, MemWrite=5, ExecuteR=6, ALUWB=7, ExecuteI=8, JAL=9, BEQ=10; encodings 11-15 SHALL go to Fetch on the next clock.
REQ-014 Transitions: Fetch->Decode; MemRead->MemWB; ExecuteR, ExecuteI and JAL->ALUWB; MemWB, MemWrite, ALUWB and BEQ->Fetch.
REQ-015 Decode SHALL branch on op: 0000011 or 0100011->MemAdr; 0110011->ExecuteR; 0010011->ExecuteI; 1101111->JAL; 1100011->BEQ; any other op->Fetch, with no write enable asserted.
REQ-016 MemAdr SHALL go to MemRead when op=0000011 and to MemWrite otherwise.
REQ-017 Moore outputs SHALL be 0 unless listed here for the current state:
- Fetch: IRWrite=1, ALUSrcB=10, ResultSrc=10, PCUpdate=1.
- Decode: ALUSrcA=01, ALUSrcB=01.
- MemAdr: ALUSrcA=10, ALUSrcB=01.
- MemRead: AdrSrc=1.
- MemWB: ResultSrc=01, RegWrite=1.
- MemWrite: AdrSrc=1, MemWrite=1.
- ExecuteR: ALUSrcA=10, ALUOp=10.
- ALUWB: RegWrite=1.
- ExecuteI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
- JAL: ALUSrcA=01, ALUSrcB=10, PCUpdate=1.
- BEQ: ALUSrcA=10, ALUOp=01, Branch=1.
REQ-018 PCUpdate, Branch and ALUOp SHALL be internal signals only.
REQ-019 PCWrite SHALL equal PCUpdate OR (Branch AND Zero), combinationally, in the same cycle.
REQ-020 ALUControl SHALL be combinational from ALUOp, funct3, op[5] and funct7b5:
- ALUOp 00 -> 010.
- ALUOp 01 -> 110.
- ALUOp 10 with funct3 000 -> 110 if op[5] AND funct7b5, else 010.
- ALUOp 10 with funct3 010 -> 111; funct3 110 -> 001; funct3 111 -> 000.
- ALUOp 10 with any other funct3 -> 010.
REQ-021 ImmSrc SHALL be combinational from op: 0000011 or 0010011 -> 00; 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; any other op -> 00.
REQ-022 Per-instruction latency SHALL be: lw 5 cycles; sw 4; R-type 4; I-type ALU 4; jal 4; beq 3; unsupported op 2.
REQ-023 At most one of MemWrite, RegWrite and IRWrite SHALL be 1 in any cycle.

Reset
REQ-024 When reset=1 at a rising edge, state SHALL become Fetch, regardless of the current state or any in-flight instruction.
REQ-025 The cycle after reset SHALL present the Fetch outputs: IRWrite=1, PCWrite=1, ALUControl=010, MemWrite=0, RegWrite=0.
REQ-026 Reset asserted in MemWrite or ALUWB SHALL NOT delay the write in that cycle (outputs are combinational from state), and no further writes SHALL follow.

Verification
REQ-027 lw (op=0000011) from reset -> states 0,1,2,3,4,0; RegWrite=1 only in state 4 with ResultSrc=01; ALUControl=010 in state 2.
REQ-028 sub (op=0110011, funct3=000, funct7b5=1) -> states 0,1,6,7,0; ALUControl=110 in state 6. With funct7b5=0 -> 010. slt (funct3=010) -> 111.
REQ-029 beq (op=1100011): Zero=1 in state 10 -> PCWrite=1 and ALUControl=110; Zero=0 -> PCWrite=0; both cases return to state 0 the next cycle.
REQ-030 jal (op=1101111) -> states 0,1,9,7,0; PCWrite=1 in states 0 and 9; ImmSrc=11.
REQ-031 Unsupported op=0000000 -> states 0,1,0; MemWrite=0 and RegWrite=0 throughout.
REQ-032 Reset asserted in state 5 (sw) -> MemWrite=1 for that single cycle, then state=0 with MemWrite=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Control unit for a multicycle RV32I-subset datapath (lw, sw, R-type,
// I-type ALU, jal, beq). A Moore main FSM sequences each instruction through
// Fetch/Decode and its execute states. Small combinational decoders produce
// the ALU operation and the immediate format.
//
// Ports
//   clk         in   1  rising-edge clock for all state
//   reset       in   1  synchronous, active-high; forces Fetch
//   op          in   7  instruction opcode, bits [6:0]
//   funct3      in   3  instruction bits [14:12]
//   funct7b5    in   1  instruction bit 30
//   Zero        in   1  ALU zero flag for the current cycle
//   PCWrite     out  1  PC load enable (unconditional update or taken beq)
//   AdrSrc      out  1  memory address select (0 = PC, 1 = ALU result)
//   MemWrite    out  1  data memory write enable
//   IRWrite     out  1  instruction register load enable
//   RegWrite    out  1  register file write enable
//   ResultSrc   out  2  result mux select
//   ALUSrcA     out  2  ALU operand A select
//   ALUSrcB     out  2  ALU operand B select
//   ImmSrc      out  2  immediate format select
//   ALUControl  out  3  ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//   state       out  4  current state encoding (debug only)
// -----------------------------------------------------------------------------
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic [3:0] state
);

    // Encodings are visible on the debug port, so they are fixed explicitly.
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE_R = 4'd6,
        S_ALU_WB    = 4'd7,
        S_EXECUTE_I = 4'd8,
        S_JAL       = 4'd9,
        S_BEQ       = 4'd10
    } state_t;

    // Coarse ALU request from the FSM; the ALU decoder refines FUNCT.
    typedef enum logic [1:0] {
        ALU_OP_ADD   = 2'b00,
        ALU_OP_SUB   = 2'b01,
        ALU_OP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BEQ    = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t  state_q;
    state_t  state_d;
    logic    pc_update;
    logic    branch;
    alu_op_t alu_op;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: default assigned first so no path leaves state_d unassigned
        // (which would infer a latch).
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
                    OP_R_TYPE:         state_d = S_EXECUTE_R;
                    OP_I_ALU:          state_d = S_EXECUTE_I;
                    OP_JAL:            state_d = S_JAL;
                    OP_BEQ:            state_d = S_BEQ;
                    // Unsupported opcodes are dropped: straight back to Fetch
                    // without touching memory or the register file.
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEM_ADR:   state_d = (op == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_d = S_MEM_WB;
            S_EXECUTE_R: state_d = S_ALU_WB;
            S_EXECUTE_I: state_d = S_ALU_WB;
            S_JAL:       state_d = S_ALU_WB;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = S_FETCH;
            S_ALU_WB:    state_d = S_FETCH;
            S_BEQ:       state_d = S_FETCH;
            // Encodings 11-15 recover to Fetch.
            default:     state_d = S_FETCH;
        endcase
    end

    // -------------------------------------------------------------------------
    // Moore outputs: everything inactive unless the current state says so.
    // Illegal encodings fall into the default and drive nothing, so a
    // corrupted state register can never cause a write.
    // -------------------------------------------------------------------------
    always_comb begin
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        pc_update = 1'b0;
        branch    = 1'b0;
        alu_op    = ALU_OP_ADD;
        case (state_q)
            S_FETCH: begin
                // PC + 4 through the ALU while the instruction is latched.
                IRWrite   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_update = 1'b1;
            end
            S_DECODE: begin
                // Speculative branch target old_pc + imm.
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEM_ADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEM_READ: begin
                AdrSrc = 1'b1;
            end
            S_MEM_WB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
            end
            S_MEM_WRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE_R: begin
                ALUSrcA = 2'b10;
                alu_op  = ALU_OP_FUNCT;
            end
            S_ALU_WB: begin
                RegWrite = 1'b1;
            end
            S_EXECUTE_I: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = ALU_OP_FUNCT;
            end
            S_JAL: begin
                // ALU forms the link value old_pc + 4; PC takes the target.
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            S_BEQ: begin
                // rs1 - rs2; the branch is taken when the difference is zero.
                ALUSrcA = 2'b10;
                alu_op  = ALU_OP_SUB;
                branch  = 1'b1;
            end
            default: ;
        endcase
    end

    // Zero is consumed in the same cycle, so PCWrite stays combinational.
    assign PCWrite = pc_update | (branch & Zero);

    // -------------------------------------------------------------------------
    // ALU decoder
    // -------------------------------------------------------------------------
    always_comb begin
        ALUControl = ALU_ADD;
        case (alu_op)
            ALU_OP_ADD: ALUControl = ALU_ADD;
            ALU_OP_SUB: ALUControl = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct3)
                    // Only R-type (op[5]=1) with bit 30 set is a subtract;
                    // addi with a negative immediate also has bit 30 set.
                    F3_ADD_SUB: ALUControl = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
                    F3_SLT:     ALUControl = ALU_SLT;
                    F3_OR:      ALUControl = ALU_OR;
                    F3_AND:     ALUControl = ALU_AND;
                    default:    ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

    // -------------------------------------------------------------------------
    // Immediate format decoder (I=00, S=01, B=10, J=11)
    // -------------------------------------------------------------------------
    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_LOAD, OP_I_ALU: ImmSrc = 2'b00;
            OP_STORE:          ImmSrc = 2'b01;
            OP_BEQ:            ImmSrc = 2'b10;
            OP_JAL:            ImmSrc = 2'b11;
            default:           ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Self-checking bench for multicycle_controller. A reference model gives the
// state path of each instruction class and the output set of each state; the
// bench runs directed and randomized instructions and compares every cycle's
// observed outputs, the per-instruction latency and the single-writer rule.
// Mid-instruction reset is exercised in MemWrite, ALUWB and random states.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic [2:0] alu_control;
        logic [3:0] state;
    } obs_t;

    typedef int path_t[$];

    obs_t got_q[$];

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (zero),
        .PCWrite    (pc_write),
        .AdrSrc     (adr_src),
        .MemWrite   (mem_write),
        .IRWrite    (ir_write),
        .RegWrite   (reg_write),
        .ResultSrc  (result_src),
        .ALUSrcA    (alu_src_a),
        .ALUSrcB    (alu_src_b),
        .ImmSrc     (imm_src),
        .ALUControl (alu_control),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    // Sequence of states an instruction visits, starting at Fetch.
    function automatic path_t expected_path(input logic [6:0] o);
        path_t p;
        case (o)
            7'b0000011: p = '{0, 1, 2, 3, 4};
            7'b0100011: p = '{0, 1, 2, 5};
            7'b0110011: p = '{0, 1, 6, 7};
            7'b0010011: p = '{0, 1, 8, 7};
            7'b1101111: p = '{0, 1, 9, 7};
            7'b1100011: p = '{0, 1, 10};
            default:    p = '{0, 1};
        endcase
        return p;
    endfunction

    // Outputs required while sitting in state st with the given inputs.
    function automatic obs_t model_out(input int st, input logic [6:0] o,
                                       input logic [2:0] f3, input logic f7,
                                       input logic z);
        obs_t       e;
        logic       pc_upd;
        logic       br;
        logic [1:0] alu_op;
        e      = '0;
        pc_upd = 1'b0;
        br     = 1'b0;
        alu_op = 2'b00;
        case (st)
            0:  begin e.ir_write = 1; e.alu_src_b = 2'b10; e.result_src = 2'b10; pc_upd = 1; end
            1:  begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b01; end
            2:  begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
            3:  begin e.adr_src = 1; end
            4:  begin e.result_src = 2'b01; e.reg_write = 1; end
            5:  begin e.adr_src = 1; e.mem_write = 1; end
            6:  begin e.alu_src_a = 2'b10; alu_op = 2'b10; end
            7:  begin e.reg_write = 1; end
            8:  begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; alu_op = 2'b10; end
            9:  begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; pc_upd = 1; end
            10: begin e.alu_src_a = 2'b10; alu_op = 2'b01; br = 1; end
            default: ;
        endcase
        e.pc_write = pc_upd | (br & z);
        if (alu_op == 2'b00)      e.alu_control = 3'b010;
        else if (alu_op == 2'b01) e.alu_control = 3'b110;
        else begin
            case (f3)
                3'b000:  e.alu_control = (o[5] && f7) ? 3'b110 : 3'b010;
                3'b010:  e.alu_control = 3'b111;
                3'b110:  e.alu_control = 3'b001;
                3'b111:  e.alu_control = 3'b000;
                default: e.alu_control = 3'b010;
            endcase
        end
        case (o)
            7'b0100011: e.imm_src = 2'b01;
            7'b1100011: e.imm_src = 2'b10;
            7'b1101111: e.imm_src = 2'b11;
            default:    e.imm_src = 2'b00;
        endcase
        e.state = st[3:0];
        return e;
    endfunction

    // -------------------------------------------------------------- drivers
    function automatic obs_t sample_dut();
        obs_t s;
        s = '{pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
              alu_src_a, alu_src_b, imm_src, alu_control, state};
        return s;
    endfunction

    // Runs one instruction starting in Fetch; records one sample per cycle
    // until the DUT is back in Fetch (bounded at 12 cycles).
    task automatic exec(input logic [6:0] o, input logic [2:0] f3,
                        input logic f7, input logic z);
        obs_t cur;
        got_q.delete();
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        zero     = z;
        for (int i = 0; i < 12; i++) begin
            #1;
            cur = sample_dut();
            if (i > 0 && cur.state == 4'd0) break;
            got_q.push_back(cur);
            @(negedge clk);
        end
    endtask

    function automatic int writer_count(input obs_t s);
        return int'(s.mem_write) + int'(s.reg_write) + int'(s.ir_write);
    endfunction

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (state !== 4'd0) $display("FAIL reset_state: got %0d expected 0", state);
        else n_pass++;
        n_checks++;
        if ({ir_write, pc_write, alu_control, mem_write, reg_write} !== {1'b1, 1'b1, 3'b010, 1'b0, 1'b0})
            $display("FAIL reset_fetch_outputs: got ir=%b pc=%b alu=%b mw=%b rw=%b expected 1 1 010 0 0",
                     ir_write, pc_write, alu_control, mem_write, reg_write);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_lw();
        path_t p;
        obs_t  e;
        exec(7'b0000011, 3'($urandom), 1'($urandom), 1'($urandom));
        p = expected_path(7'b0000011);
        n_checks++;
        if (got_q.size() !== p.size()) $display("FAIL lw_latency: got %0d expected %0d", got_q.size(), p.size());
        else n_pass++;
        for (int i = 0; i < p.size() && i < got_q.size(); i++) begin
            e = model_out(p[i], op, funct3, funct7b5, zero);
            n_checks++;
            if (got_q[i] !== e) $display("FAIL lw_cycle%0d: got %h expected %h", i, got_q[i], e);
            else n_pass++;
        end
    endtask

    task automatic test_rtype();
        logic [2:0] f3_tab [6] = '{3'b000, 3'b000, 3'b010, 3'b110, 3'b111, 3'b011};
        logic       f7_tab [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        path_t p;
        obs_t  e;
        for (int t = 0; t < 6; t++) begin
            exec(7'b0110011, f3_tab[t], f7_tab[t], 1'($urandom));
            p = expected_path(7'b0110011);
            n_checks++;
            if (got_q.size() !== p.size()) $display("FAIL rtype%0d_latency: got %0d expected %0d", t, got_q.size(), p.size());
            else n_pass++;
            for (int i = 0; i < p.size() && i < got_q.size(); i++) begin
                e = model_out(p[i], op, funct3, funct7b5, zero);
                n_checks++;
                if (got_q[i] !== e) $display("FAIL rtype%0d_cycle%0d: got %h expected %h", t, i, got_q[i], e);
                else n_pass++;
            end
        end
        // addi with bit 30 set must still add.
        exec(7'b0010011, 3'b000, 1'b1, 1'b0);
        n_checks++;
        if (got_q.size() < 3 || got_q[2].alu_control !== 3'b010 || got_q[2].state !== 4'd8)
            $display("FAIL addi_bit30: got state=%0d alu=%b expected 8 010",
                     got_q.size() >= 3 ? got_q[2].state : 4'hf, got_q.size() >= 3 ? got_q[2].alu_control : 3'bxxx);
        else n_pass++;
    endtask

    task automatic test_beq();
        path_t p;
        obs_t  e;
        for (int z = 0; z < 2; z++) begin
            exec(7'b1100011, 3'b000, 1'b0, 1'(z));
            p = expected_path(7'b1100011);
            n_checks++;
            if (got_q.size() !== p.size()) $display("FAIL beq_z%0d_latency: got %0d expected %0d", z, got_q.size(), p.size());
            else n_pass++;
            for (int i = 0; i < p.size() && i < got_q.size(); i++) begin
                e = model_out(p[i], op, funct3, funct7b5, zero);
                n_checks++;
                if (got_q[i] !== e) $display("FAIL beq_z%0d_cycle%0d: got %h expected %h", z, i, got_q[i], e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_jal();
        path_t p;
        obs_t  e;
        exec(7'b1101111, 3'($urandom), 1'($urandom), 1'($urandom));
        p = expected_path(7'b1101111);
        n_checks++;
        if (got_q.size() !== p.size()) $display("FAIL jal_latency: got %0d expected %0d", got_q.size(), p.size());
        else n_pass++;
        for (int i = 0; i < p.size() && i < got_q.size(); i++) begin
            e = model_out(p[i], op, funct3, funct7b5, zero);
            n_checks++;
            if (got_q[i] !== e) $display("FAIL jal_cycle%0d: got %h expected %h", i, got_q[i], e);
            else n_pass++;
        end
    endtask

    task automatic test_unsupported();
        logic [6:0] op_tab [3] = '{7'b0000000, 7'b1111111, 7'b0010111};
        path_t p;
        obs_t  e;
        for (int t = 0; t < 3; t++) begin
            exec(op_tab[t], 3'($urandom), 1'($urandom), 1'($urandom));
            p = expected_path(op_tab[t]);
            n_checks++;
            if (got_q.size() !== p.size()) $display("FAIL unsup%0d_latency: got %0d expected %0d", t, got_q.size(), p.size());
            else n_pass++;
            for (int i = 0; i < p.size() && i < got_q.size(); i++) begin
                e = model_out(p[i], op, funct3, funct7b5, zero);
                n_checks++;
                if (got_q[i] !== e) $display("FAIL unsup%0d_cycle%0d: got %h expected %h", t, i, got_q[i], e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        logic [6:0] pool [6] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
        logic [6:0] o;
        int         k;
        path_t      p;
        obs_t       e;
        for (int t = 0; t < 40; t++) begin
            k = int'($urandom_range(0, 6));
            o = (k == 6) ? 7'($urandom) : pool[k];
            exec(o, 3'($urandom), 1'($urandom), 1'($urandom));
            p = expected_path(o);
            n_checks++;
            if (got_q.size() !== p.size()) $display("FAIL rand%0d_latency op=%b: got %0d expected %0d", t, o, got_q.size(), p.size());
            else n_pass++;
            for (int i = 0; i < p.size() && i < got_q.size(); i++) begin
                e = model_out(p[i], op, funct3, funct7b5, zero);
                n_checks++;
                if (got_q[i] !== e) $display("FAIL rand%0d_cycle%0d op=%b: got %h expected %h", t, i, o, got_q[i], e);
                else n_pass++;
                n_checks++;
                if (writer_count(got_q[i]) > 1) $display("FAIL rand%0d_single_writer: got %0d writers expected at most 1", t, writer_count(got_q[i]));
                else n_pass++;
            end
        end
    endtask

    // Reset while a write is in progress: the write stays visible that cycle,
    // then the DUT sits in Fetch with no write asserted.
    task automatic test_reset_midflight();
        logic [6:0] op_tab [2] = '{7'b0100011, 7'b0110011};
        logic [3:0] st_tab [2] = '{4'd5, 4'd7};
        int         k;
        for (int t = 0; t < 2; t++) begin
            op = op_tab[t];
            repeat (3) @(negedge clk);
            #1;
            n_checks++;
            if (state !== st_tab[t] || (mem_write | reg_write) !== 1'b1)
                $display("FAIL midreset%0d_write: got state=%0d mw=%b rw=%b expected state=%0d with write", t, state, mem_write, reg_write, st_tab[t]);
            else n_pass++;
            reset = 1'b1;
            @(negedge clk);
            #1;
            n_checks++;
            if ({state, mem_write, reg_write, ir_write} !== {4'd0, 1'b0, 1'b0, 1'b1})
                $display("FAIL midreset%0d_after: got state=%0d mw=%b rw=%b ir=%b expected 0 0 0 1", t, state, mem_write, reg_write, ir_write);
            else n_pass++;
            op    = 7'd0;
            reset = 1'b0;
        end
        // Reset from a random point inside a load.
        for (int t = 0; t < 4; t++) begin
            op = 7'b0000011;
            k  = int'($urandom_range(1, 4));
            repeat (k) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            #1;
            n_checks++;
            if (state !== 4'd0) $display("FAIL midreset_lw%0d: got state=%0d expected 0", k, state);
            else n_pass++;
            reset = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_jal();
        test_unsupported();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
